board_io_peripheral: RTL and testbench

Parametrised memory-mapped board I/O peripheral on the processor's shared 64-bit data/address bus, replacing direct wiring of LEDs and switches in the board top level. Provides a writable LED register, debounced switch and button inputs, sticky button-press flags with write-1-to-clear, and a multi-digit hex display register decoded to active-low seven-segment outputs. Instantiated beside the GPU and SD card peripherals in the DE0 top level.

---
 rtl/board_io_peripheral.sv | 178 +++++++++++++++++
 tb/tb_board_io_peripheral.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/board_io_peripheral.sv
// Memory-mapped board I/O: LED register, debounced switches/buttons, sticky
// button-press flags (W1C) and a blankable multi-digit seven-segment display.
module board_io_peripheral #(
    parameter logic [63:0] BASE_ADDR       = 64'h0000_0000_0001_0000,
    parameter int          LED_COUNT       = 10,
    parameter int          SW_COUNT        = 10,
    parameter int          BUTTON_COUNT    = 3,
    parameter int          HEX_DIGITS      = 4,
    parameter int          DEBOUNCE_CYCLES = 500000
) (
    input  logic                    clock,
    input  logic                    reset,
    inout  logic [63:0]             data,
    input  logic [63:0]             address,
    input  logic                    read,
    input  logic                    write,
    input  logic [SW_COUNT-1:0]     sw,
    input  logic [BUTTON_COUNT-1:0] button,
    output logic [LED_COUNT-1:0]    led,
    output logic [7*HEX_DIGITS-1:0] hex
);

    localparam int IN_W  = SW_COUNT + BUTTON_COUNT;
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] OFF_LED    = 3'd0;
    localparam logic [2:0] OFF_SWITCH = 3'd1;
    localparam logic [2:0] OFF_BUTTON = 3'd2;
    localparam logic [2:0] OFF_PRESS  = 3'd3;
    localparam logic [2:0] OFF_HEX    = 3'd4;
    localparam logic [2:0] OFF_BLANK  = 3'd5;

    // Active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        logic [6:0] seg;
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // Buttons are inverted ahead of the flops so that a cleared synchroniser
    // already means "not pressed" and reset can never fake a press.
    logic [IN_W-1:0] pin_level;
    logic [IN_W-1:0] sync1_reg;
    logic [IN_W-1:0] sync2_reg;
    logic [IN_W-1:0] stable_reg;
    logic [IN_W-1:0] stable_next;
    logic [IN_W-1:0] accept;

    assign pin_level = {~button, sw};

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_reg  <= '0;
            sync2_reg  <= '0;
            stable_reg <= '0;
        end else begin
            sync1_reg  <= pin_level;
            sync2_reg  <= sync1_reg;
            stable_reg <= stable_next;
        end
    end

    assign stable_next = (stable_reg & ~accept) | (sync2_reg & accept);

    genvar gi;
    generate
        for (gi = 0; gi < IN_W; gi++) begin : g_debounce
            logic [CNT_W-1:0] cnt_reg;
            logic             differ;

            assign differ     = sync2_reg[gi] != stable_reg[gi];
            assign accept[gi] = differ && (cnt_reg == CNT_LAST);

            always_ff @(posedge clock) begin
                if (reset || !differ || accept[gi]) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    logic [SW_COUNT-1:0]     sw_stable;
    logic [BUTTON_COUNT-1:0] btn_stable;
    logic [BUTTON_COUNT-1:0] btn_rise;

    assign sw_stable  = stable_reg[SW_COUNT-1:0];
    assign btn_stable = stable_reg[IN_W-1:SW_COUNT];
    // A button rises exactly when its debouncer accepts a pressed level.
    assign btn_rise   = accept[IN_W-1:SW_COUNT] & sync2_reg[IN_W-1:SW_COUNT];

    logic       hit;
    logic [2:0] offset;
    logic       wr_hit;
    logic       rd_drive;

    assign hit      = address[63:6] == BASE_ADDR[63:6];
    assign offset   = address[5:3];
    assign wr_hit   = hit && write;
    assign rd_drive = hit && read && !write;

    logic [LED_COUNT-1:0]    led_reg;
    logic [4*HEX_DIGITS-1:0] hex_reg;
    logic [HEX_DIGITS-1:0]   blank_reg;
    logic [BUTTON_COUNT-1:0] press_reg;
    logic [BUTTON_COUNT-1:0] press_clear;

    assign press_clear = (wr_hit && offset == OFF_PRESS) ? data[BUTTON_COUNT-1:0] : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            led_reg   <= '0;
            hex_reg   <= '0;
            blank_reg <= '1;
            press_reg <= '0;
        end else begin
            if (wr_hit && offset == OFF_LED) begin
                led_reg <= data[LED_COUNT-1:0];
            end
            if (wr_hit && offset == OFF_HEX) begin
                hex_reg <= data[4*HEX_DIGITS-1:0];
            end
            if (wr_hit && offset == OFF_BLANK) begin
                blank_reg <= data[HEX_DIGITS-1:0];
            end
            press_reg <= (press_reg & ~press_clear) | btn_rise;
        end
    end

    logic [63:0] rdata;

    always_comb begin
        rdata = '0;
        case (offset)
            OFF_LED:    rdata = 64'(led_reg);
            OFF_SWITCH: rdata = 64'(sw_stable);
            OFF_BUTTON: rdata = 64'(btn_stable);
            OFF_PRESS:  rdata = 64'(press_reg);
            OFF_HEX:    rdata = 64'(hex_reg);
            OFF_BLANK:  rdata = 64'(blank_reg);
            default:    rdata = '0;
        endcase
    end

    assign data = rd_drive ? rdata : 'z;
    assign led  = led_reg;

    generate
        for (gi = 0; gi < HEX_DIGITS; gi++) begin : g_hex
            assign hex[7*gi +: 7] = blank_reg[gi] ? 7'h7F : seg_decode(hex_reg[4*gi +: 4]);
        end
    endgenerate

    logic unused_bits;
    assign unused_bits = ^{address[2:0], data};

endmodule

// File: tb/tb_board_io_peripheral.sv
// Self-checking bench for board_io_peripheral with a short debounce window.
module tb_board_io_peripheral;

    localparam logic [63:0] BASE = 64'h0000_0000_0001_0000;
    localparam int DC = 16;

    localparam logic [63:0] A_LED    = BASE + 64'h00;
    localparam logic [63:0] A_SWITCH = BASE + 64'h08;
    localparam logic [63:0] A_BUTTON = BASE + 64'h10;
    localparam logic [63:0] A_PRESS  = BASE + 64'h18;
    localparam logic [63:0] A_HEX    = BASE + 64'h20;
    localparam logic [63:0] A_BLANK  = BASE + 64'h28;
    localparam logic [27:0] HEX_OFF  = 28'hFFF_FFFF;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] address;
    logic        read;
    logic        write;
    logic [9:0]  sw;
    logic [2:0]  button;
    logic [9:0]  led;
    logic [27:0] hex;
    logic [63:0] tb_data;
    logic        tb_oe;
    wire  [63:0] data;

    assign data = tb_oe ? tb_data : 'z;

    board_io_peripheral #(
        .BASE_ADDR      (BASE),
        .LED_COUNT      (10),
        .SW_COUNT       (10),
        .BUTTON_COUNT   (3),
        .HEX_DIGITS     (4),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .data   (data),
        .address(address),
        .read   (read),
        .write  (write),
        .sw     (sw),
        .button (button),
        .led    (led),
        .hex    (hex)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        logic [63:0] waddr;
        logic [63:0] wdata;
        logic [63:0] raddr;
        logic [63:0] exp_rd;
        logic [9:0]  exp_led;
        logic [27:0] exp_hex;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic logic [63:0] bus_value();
        return $isunknown(data) ? 64'h0 : data;
    endfunction

    // Read in the current cycle without waiting for a clock edge.
    task automatic read_now(input logic [63:0] a, input logic [63:0] exp, input string name);
        address = a;
        read    = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        #1;
        check(name_q.pop_front(), data, exp_q.pop_front());
        read = 1'b0;
    endtask

    task automatic bus_read(input logic [63:0] a, input logic [63:0] exp, input string name);
        @(negedge clock);
        read_now(a, exp, name);
    endtask

    task automatic bus_write(input logic [63:0] a, input logic [63:0] v);
        @(negedge clock);
        address = a;
        tb_data = v;
        tb_oe   = 1'b1;
        write   = 1'b1;
        @(posedge clock);
        #1;
        write = 1'b0;
        tb_oe = 1'b0;
    endtask

    initial begin
        vecs[0] = '{A_LED, 64'hFFFF_FFFF_FFFF_F2A5, A_LED, 64'h2A5, 10'h2A5, HEX_OFF};
        vecs[1] = '{BASE + 64'h40, 64'h0, A_LED, 64'h2A5, 10'h2A5, HEX_OFF};
        vecs[2] = '{A_HEX, 64'hF81A, A_HEX, 64'hF81A, 10'h2A5, HEX_OFF};
        vecs[3] = '{A_BLANK, 64'h0, A_BLANK, 64'h0, 10'h2A5, {7'h0E, 7'h00, 7'h79, 7'h08}};
        vecs[4] = '{A_BLANK, 64'h2, A_BLANK, 64'h2, 10'h2A5, {7'h0E, 7'h00, 7'h7F, 7'h08}};
        vecs[5] = '{A_SWITCH, 64'hFFF, A_SWITCH, 64'h0, 10'h2A5, {7'h0E, 7'h00, 7'h7F, 7'h08}};
        vecs[6] = '{BASE + 64'h30, 64'hFFFF, BASE + 64'h30, 64'h0, 10'h2A5, {7'h0E, 7'h00, 7'h7F, 7'h08}};
        vecs[7] = '{BASE + 64'h07, 64'h155, BASE + 64'h05, 64'h155, 10'h155, {7'h0E, 7'h00, 7'h7F, 7'h08}};
        vecs[8] = '{A_HEX, 64'hABCD_0000_0000_3C59, A_HEX, 64'h3C59, 10'h155, {7'h30, 7'h46, 7'h7F, 7'h10}};

        reset   = 1'b1;
        address = '0;
        read    = 1'b0;
        write   = 1'b0;
        tb_data = '0;
        tb_oe   = 1'b0;
        sw      = '0;
        button  = 3'b111;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            bus_read(BASE + 64'(8 * i), (i == 5) ? 64'hF : 64'h0, $sformatf("reset_off%0d", i));
        end
        check("reset_hex", 64'(hex), 64'(HEX_OFF));
        check("reset_led", 64'(led), 64'h0);

        for (int i = 0; i < 9; i++) begin
            bus_write(vecs[i].waddr, vecs[i].wdata);
            bus_read(vecs[i].raddr, vecs[i].exp_rd, $sformatf("vec%0d_read", i));
            check($sformatf("vec%0d_led", i), 64'(led), 64'(vecs[i].exp_led));
            check($sformatf("vec%0d_hex", i), 64'(hex), 64'(vecs[i].exp_hex));
        end

        // Bus must float when not a read hit (LED is 0x155 here).
        @(negedge clock);
        address = A_LED;
        read    = 1'b0;
        #1;
        check("nodrive_idle", bus_value(), 64'h0);
        address = BASE + 64'h40;
        read    = 1'b1;
        #1;
        check("nodrive_above", bus_value(), 64'h0);
        address = 64'h0;
        #1;
        check("nodrive_zero", bus_value(), 64'h0);
        read = 1'b0;

        // Switch glitch shorter than the debounce window.
        @(posedge clock);
        #1;
        sw[3] = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        sw[3] = 1'b0;
        repeat (30) @(posedge clock);
        bus_read(A_SWITCH, 64'h0, "sw_glitch");

        // Held switch: accepted on the 18th edge after the pin change.
        @(posedge clock);
        #1;
        sw[3] = 1'b1;
        repeat (DC + 1) @(posedge clock);
        #1;
        read_now(A_SWITCH, 64'h0, "sw_edge17");
        @(posedge clock);
        #1;
        read_now(A_SWITCH, 64'h8, "sw_edge18");

        // Button press, sticky flag, release, W1C.
        @(posedge clock);
        #1;
        button[1] = 1'b0;
        repeat (DC + 1) @(posedge clock);
        #1;
        read_now(A_BUTTON, 64'h0, "btn_edge17");
        read_now(A_PRESS, 64'h0, "press_edge17");
        @(posedge clock);
        #1;
        read_now(A_BUTTON, 64'h2, "btn_edge18");
        read_now(A_PRESS, 64'h2, "press_edge18");
        button[1] = 1'b1;
        repeat (DC + 8) @(posedge clock);
        bus_read(A_BUTTON, 64'h0, "btn_release");
        bus_read(A_PRESS, 64'h2, "press_sticky");
        bus_write(A_PRESS, 64'h2);
        bus_read(A_PRESS, 64'h0, "press_w1c");

        // W1C of PRESS[0] on the very edge its debounced level rises: set wins.
        @(posedge clock);
        #1;
        button[0] = 1'b0;
        repeat (DC + 1) @(posedge clock);
        #1;
        address = A_PRESS;
        tb_data = 64'h1;
        tb_oe   = 1'b1;
        write   = 1'b1;
        @(posedge clock);
        #1;
        write = 1'b0;
        tb_oe = 1'b0;
        read_now(A_PRESS, 64'h1, "press_set_wins");
        read_now(A_BUTTON, 64'h1, "btn0_pressed");
        button[0] = 1'b1;

        // Simultaneous read and write: write performed, DUT does not drive.
        @(negedge clock);
        address = A_LED;
        tb_data = 64'h0AA;
        tb_oe   = 1'b1;
        read    = 1'b1;
        write   = 1'b1;
        #1;
        check("rw_bus", data, 64'h0AA);
        @(posedge clock);
        #1;
        read  = 1'b0;
        write = 1'b0;
        tb_oe = 1'b0;
        check("rw_led", 64'(led), 64'h0AA);
        bus_read(A_LED, 64'h0AA, "rw_readback");

        // Reset dominates a concurrent write.
        @(negedge clock);
        address = A_LED;
        tb_data = 64'h3FF;
        tb_oe   = 1'b1;
        write   = 1'b1;
        reset   = 1'b1;
        @(posedge clock);
        #1;
        write = 1'b0;
        tb_oe = 1'b0;
        reset = 1'b0;
        check("rst_write_led", 64'(led), 64'h0);
        check("rst_write_hex", 64'(hex), 64'(HEX_OFF));
        bus_read(A_BLANK, 64'hF, "rst_write_blank");
        bus_read(A_PRESS, 64'h0, "rst_write_press");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
